negate_32bit: RTL and testbench

Registered 32-bit arithmetic negation unit for the datapath ALU. It computes the two's complement (Rz = -Ra) or, when selected, the one's complement (Rz = ~Ra) of a 32-bit operand. It is built as a bitwise invert followed by a conditional +1 through an internal 32-bit carry chain. The result is registered, so the ALU sees it one clock after the operand is presented, with overflow and zero status flags.

---
 rtl/negate_32bit.sv | 111 +++++++++++
 tb/tb_negate_32bit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/negate_32bit.sv
`default_nettype none
// ============================================================================
//  Module      : negate_32bit
//  Description : Registered arithmetic negation unit. Produces -Ra (two's
//                complement) or ~Ra (one's complement) one clock after the
//                operand is captured, with signed-overflow and zero flags.
//                The +1 is formed by a grouped carry-lookahead increment
//                chain fed by the inverted operand.
//  Revision    : 1.0 - initial release
// ============================================================================
module negate_32bit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] Ra,
    input  logic             ones_comp,
    input  logic             valid_in,
    output logic [WIDTH-1:0] Rz,
    output logic             valid_out,
    output logic             ovf,
    output logic             zero
);

    // Lookahead group size and the padded width covering all groups.
    localparam int c_GRP_W  = 4;
    localparam int c_NGRP   = (WIDTH + c_GRP_W - 1) / c_GRP_W;
    localparam int c_PAD_W  = c_NGRP * c_GRP_W;

    // Most negative representable value: the only operand whose negation
    // cannot be represented.
    localparam logic [WIDTH-1:0] c_MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0]   w_inv;       // bitwise inverted operand
    logic               w_cin;       // +1 injected only in two's-complement mode
    logic [c_PAD_W-1:0] w_p_pad;     // per-bit propagate, zero padded to group size
    logic [c_PAD_W-1:0] w_c_pad;     // carry into each bit position
    logic [c_NGRP-1:0]  w_gcarry;    // carry into each lookahead group
    logic [WIDTH-1:0]   w_sum;       // combinational result
    logic               w_is_min;    // operand equals the most negative value
    logic               w_ovf;
    logic               w_zero;

    logic [WIDTH-1:0]   r_rz;
    logic               r_valid;
    logic               r_ovf;
    logic               r_zero;

    assign w_inv = ~Ra;
    assign w_cin = ~ones_comp;

    // Widen the propagate vector so every group is full; padding bits never
    // reach the result.
    always_comb begin
        w_p_pad             = '0;
        w_p_pad[WIDTH-1:0]  = w_inv;
    end

    assign w_gcarry[0] = w_cin;

    // Incrementing has no generate terms (the addend is zero), so a carry
    // into bit i exists exactly when cin is set and every lower inverted bit
    // is 1. Each group resolves its internal carries in parallel from the
    // group carry-in; group carries ripple using the group propagate.
    generate
        for (genvar g = 0; g < c_NGRP; g++) begin : g_grp
            for (genvar k = 0; k < c_GRP_W; k++) begin : g_bit
                if (k == 0) begin : g_first
                    assign w_c_pad[g*c_GRP_W] = w_gcarry[g];
                end else begin : g_rest
                    assign w_c_pad[g*c_GRP_W + k] =
                        w_gcarry[g] & (&w_p_pad[g*c_GRP_W +: k]);
                end
            end
            // The carry out of the top group is discarded (modulo 2^WIDTH).
            if (g < c_NGRP - 1) begin : g_cout
                assign w_gcarry[g+1] = w_gcarry[g] & (&w_p_pad[g*c_GRP_W +: c_GRP_W]);
            end
        end
    endgenerate

    assign w_sum    = w_inv ^ w_c_pad[WIDTH-1:0];
    assign w_is_min = (Ra == c_MIN_NEG);
    assign w_ovf    = w_cin & w_is_min;
    assign w_zero   = (w_sum == '0);

    // Capture a fresh result when valid_in is high; otherwise hold the data
    // and flags and drop valid_out. clr flushes everything asynchronously.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_rz    <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else if (valid_in) begin
            r_rz    <= w_sum;
            r_valid <= 1'b1;
            r_ovf   <= w_ovf;
            r_zero  <= w_zero;
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign Rz        = r_rz;
    assign valid_out = r_valid;
    assign ovf       = r_ovf;
    assign zero      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_negate_32bit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_negate_32bit
//  Description : Self-checking bench for negate_32bit. A behavioural model
//                computes results from plain arithmetic; a compare process
//                checks every output on each falling edge, and directed
//                vectors pin hand-computed values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_negate_32bit;

    logic        clk;
    logic        clr;
    logic [31:0] Ra;
    logic        ones_comp;
    logic        valid_in;
    logic [31:0] Rz;
    logic        valid_out;
    logic        ovf;
    logic        zero;

    int total;
    int bad;
    bit chk_en;

    // Behavioural model state
    logic [31:0] m_rz;
    logic        m_vo;
    logic        m_ovf;
    logic        m_zero;

    negate_32bit #(.WIDTH(32)) dut (
        .clk       (clk),
        .clr       (clr),
        .Ra        (Ra),
        .ones_comp (ones_comp),
        .valid_in  (valid_in),
        .Rz        (Rz),
        .valid_out (valid_out),
        .ovf       (ovf),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: result from arithmetic negation; overflow when the true signed
    // negation does not fit in 32 bits.
    always @(posedge clk or posedge clr) begin
        if (clr) begin
            m_rz   <= 32'h0;
            m_vo   <= 1'b0;
            m_ovf  <= 1'b0;
            m_zero <= 1'b0;
        end else if (valid_in) begin
            longint neg;
            logic [31:0] res;
            neg = -longint'($signed(Ra));
            res = ones_comp ? ~Ra : (32'd0 - Ra);
            m_rz   <= res;
            m_vo   <= 1'b1;
            m_ovf  <= !ones_comp && (neg > 64'sd2147483647);
            m_zero <= (res == 32'h0);
        end else begin
            m_vo <= 1'b0;
        end
    end

    // Compare every output against the model away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmp_rz",    Rz,               m_rz);
            chk("cmp_valid", {31'b0, valid_out}, {31'b0, m_vo});
            chk("cmp_ovf",   {31'b0, ovf},       {31'b0, m_ovf});
            chk("cmp_zero",  {31'b0, zero},      {31'b0, m_zero});
        end
    end

    // Present one operand for one cycle, then sample just after the edge.
    task automatic apply(input logic [31:0] a, input logic oc, input logic v);
        @(negedge clk);
        Ra        = a;
        ones_comp = oc;
        valid_in  = v;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string nm, input logic [31:0] rz,
                              input logic vo, input logic ov, input logic zr);
        chk({nm, "_rz"},    Rz,                rz);
        chk({nm, "_valid"}, {31'b0, valid_out}, {31'b0, vo});
        chk({nm, "_ovf"},   {31'b0, ovf},       {31'b0, ov});
        chk({nm, "_zero"},  {31'b0, zero},      {31'b0, zr});
    endtask

    // Pulse clr between edges and confirm the flush is immediate.
    task automatic clr_pulse(input string nm);
        #2;
        clr = 1'b1;
        #1;
        expect_out(nm, 32'h0, 1'b0, 1'b0, 1'b0);
        #2;
        clr = 1'b0;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        chk_en    = 1'b0;
        Ra        = 32'h0;
        ones_comp = 1'b0;
        valid_in  = 1'b0;
        clr       = 1'b0;
        #1;
        clr = 1'b1;
        #1;
        expect_out("reset", 32'h0, 1'b0, 1'b0, 1'b0);
        #12;
        clr    = 1'b0;
        chk_en = 1'b1;

        // Capture something, then flush between edges without a clock.
        apply(32'h0000_0005, 1'b0, 1'b1);
        expect_out("pre_clr", 32'hFFFF_FFFB, 1'b1, 1'b0, 1'b0);
        clr_pulse("clr_async");

        // Two's complement basics
        apply(32'hFFFF_FFFF, 1'b0, 1'b1);
        expect_out("neg_m1", 32'h0000_0001, 1'b1, 1'b0, 1'b0);
        apply(32'h8765_4321, 1'b0, 1'b1);
        expect_out("neg_8765", 32'h789A_BCDF, 1'b1, 1'b0, 1'b0);

        // One's complement
        apply(32'h0000_0000, 1'b1, 1'b1);
        expect_out("inv_0", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        apply(32'h1234_5678, 1'b1, 1'b1);
        expect_out("inv_1234", 32'hEDCB_A987, 1'b1, 1'b0, 1'b0);
        apply(32'h8000_0000, 1'b1, 1'b1);
        expect_out("inv_min", 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0);

        // Zero and overflow boundaries
        apply(32'h0000_0000, 1'b0, 1'b1);
        expect_out("neg_0", 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        apply(32'h8000_0000, 1'b0, 1'b1);
        expect_out("neg_min", 32'h8000_0000, 1'b1, 1'b1, 1'b0);

        // Back-to-back then hold
        apply(32'h0000_0001, 1'b0, 1'b1);
        expect_out("b2b_1", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        apply(32'h7FFF_FFFF, 1'b0, 1'b1);
        expect_out("b2b_max", 32'h8000_0001, 1'b1, 1'b0, 1'b0);
        apply(32'h1234_5678, 1'b0, 1'b1);
        expect_out("b2b_1234", 32'hEDCB_A988, 1'b1, 1'b0, 1'b0);
        apply(32'hDEAD_BEEF, 1'b0, 1'b0);
        expect_out("hold", 32'hEDCB_A988, 1'b0, 1'b0, 1'b0);
        apply(32'h0000_0000, 1'b0, 1'b0);
        expect_out("hold2", 32'hEDCB_A988, 1'b0, 1'b0, 1'b0);

        // Random sweep in both modes, flushed once mid-stream
        for (int i = 0; i < 1200; i++) begin
            logic [31:0] a;
            case ($urandom_range(0, 9))
                0:       a = 32'h8000_0000;
                1:       a = 32'h0000_0000;
                2:       a = 32'hFFFF_FFFF;
                3:       a = 32'h7FFF_FFFF;
                default: a = $urandom;
            endcase
            apply(a, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0));
            if (i == 600) begin
                clr_pulse("clr_mid");
            end
        end

        // First result after a flush arrives one edge after capture.
        apply(32'h0000_0002, 1'b0, 1'b1);
        clr_pulse("clr_end");
        apply(32'h0000_0003, 1'b0, 1'b1);
        expect_out("post_clr", 32'hFFFF_FFFD, 1'b1, 1'b0, 1'b0);

        @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #500000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
